// File: rtl/tone_sweep_gen_pkg.sv
// Shared types and helpers for the tone sweep generator: mode encoding,
// ramp selection from the sweep counter, and the saturating divider add.
package tone_sweep_pkg;

  typedef enum logic [1:0] {
    MODE_FIXED    = 2'd0,
    MODE_TRIANGLE = 2'd1,
    MODE_SAW      = 2'd2,
    MODE_TWO_TONE = 2'd3
  } mode_t;

  // ones is the all-ones mask of the ramp width; p arrives zero-extended.
  function automatic logic [31:0] ramp_sel(mode_t mode, logic dir,
                                           logic [31:0] p, logic [31:0] ones);
    logic [31:0] r;
    r = '0;
    case (mode)
      MODE_FIXED:    r = '0;
      MODE_TRIANGLE: r = dir ? p : (~p & ones);
      MODE_SAW:      r = p;
      MODE_TWO_TONE: r = dir ? ones : '0;
      default:       r = '0;
    endcase
    return r;
  endfunction

  // Anything past the divider range clamps to the longest half-period
  // instead of wrapping to a short (high-pitched) one.
  function automatic logic [63:0] div_sat_add(logic [63:0] base, logic [63:0] addend,
                                              logic [63:0] max_val);
    logic [63:0] sum;
    sum = base + addend;
    return (sum > max_val) ? max_val : sum;
  endfunction

endpackage

// File: rtl/tone_sweep_gen_channel.sv
// One tone channel: config registers, swept divider, half-period counter
// and the square-wave flop.
module tone_channel
  import tone_sweep_pkg::*;
#(
  parameter int DIV_WIDTH  = 19,
  parameter int RAMP_WIDTH = 7,
  parameter int SHIFT      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic                  wr_en,
  input  mode_t                 wr_mode,
  input  logic [DIV_WIDTH-1:0]  wr_base,
  input  logic                  dir,
  input  logic [RAMP_WIDTH-1:0] p,
  output logic                  spk
);

  localparam logic [63:0] DIV_MAX   = (64'd1 << DIV_WIDTH) - 64'd1;
  localparam logic [31:0] RAMP_ONES = (32'd1 << RAMP_WIDTH) - 32'd1;

  logic                 en;
  mode_t                mode;
  logic [DIV_WIDTH-1:0] base;
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] div;

  always_comb begin
    div = DIV_WIDTH'(div_sat_add(64'(base),
                                 64'(ramp_sel(mode, dir, 32'(p), RAMP_ONES)) << SHIFT,
                                 DIV_MAX));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en   <= 1'b0;
      mode <= MODE_FIXED;
      base <= '0;
    end else if (wr) begin
      en   <= wr_en;
      mode <= wr_mode;
      base <= wr_base;
    end
  end

  // div is only consumed at reload, so a config write lands on the next
  // half-period and the one in flight keeps its length.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
      spk <= 1'b0;
    end else if (cnt == '0) begin
      cnt <= div;
      spk <= ~spk;
    end else begin
      cnt <= cnt - DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/tone_sweep_gen.sv
// Multi-channel square-wave tone generator: shared sweep ramp, run-time
// channel configuration over valid/ready, per-channel outputs and an XOR mix.
module tone_sweep_gen
  import tone_sweep_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int DIV_WIDTH   = 19,
  parameter int RAMP_WIDTH  = 7,
  parameter int SWEEP_WIDTH = 24,
  parameter int SHIFT       = 6,
  localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CW-1:0]        cfg_chan,
  input  logic                 cfg_en,
  input  logic [1:0]           cfg_mode,
  input  logic [DIV_WIDTH-1:0] cfg_base,
  output logic                 cfg_err,
  output logic [CHANNELS-1:0]  spk,
  output logic                 mix
);

  logic [SWEEP_WIDTH-1:0] sweep;
  logic                   dir;
  logic [RAMP_WIDTH-1:0]  p;
  logic                   fire;
  logic                   in_range;

  assign dir      = sweep[SWEEP_WIDTH-1];
  assign p        = sweep[SWEEP_WIDTH-2 -: RAMP_WIDTH];
  // Handshake: a transfer happens on any edge where cfg_valid && cfg_ready;
  // ready then drops for one cycle, so back-to-back requests alternate.
  assign fire     = cfg_valid && cfg_ready;
  assign in_range = int'(cfg_chan) < CHANNELS;

  always_ff @(posedge clk) begin
    if (rst) begin
      sweep     <= '0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      mix       <= 1'b0;
    end else begin
      sweep     <= sweep + SWEEP_WIDTH'(1);
      cfg_ready <= !fire;
      cfg_err   <= fire && !in_range;
      mix       <= ^spk;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    tone_channel #(
      .DIV_WIDTH  (DIV_WIDTH),
      .RAMP_WIDTH (RAMP_WIDTH),
      .SHIFT      (SHIFT)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .wr      (fire && in_range && (cfg_chan == CW'(g))),
      .wr_en   (cfg_en),
      .wr_mode (mode_t'(cfg_mode)),
      .wr_base (cfg_base),
      .dir     (dir),
      .p       (p),
      .spk     (spk[g])
    );
  end

endmodule

// File: tb/tb_tone_sweep_gen.sv
// Bench for tone_sweep_gen: directed steps plus random config traffic,
// checked every cycle against an event-time model of the tone outputs.
module tb_tone_sweep_gen;

  localparam int CH = 3;
  localparam int DW = 8;
  localparam int RW = 3;
  localparam int SW = 6;
  localparam int SH = 5;
  localparam int CW = 2;
  localparam int DMAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_chan;
  logic          cfg_en;
  logic [1:0]    cfg_mode;
  logic [DW-1:0] cfg_base;
  logic          cfg_err;
  logic [CH-1:0] spk;
  logic          mix;

  always #5 clk = ~clk;

  tone_sweep_gen #(
    .CHANNELS(CH), .DIV_WIDTH(DW), .RAMP_WIDTH(RW), .SWEEP_WIDTH(SW), .SHIFT(SH)
  ) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_base(cfg_base),
    .cfg_err(cfg_err), .spk(spk), .mix(mix)
  );

  int errors = 0;
  int checks = 0;

  // Reference: each enabled channel toggles at scheduled cycle numbers;
  // the gap after a toggle is (half-period) computed from that cycle's sweep.
  int cyc = 0;
  int m_sweep = 0;
  bit m_ready = 0, m_err = 0, m_mix = 0;
  bit m_en[CH];
  int m_mode[CH], m_base[CH], m_next[CH];
  bit m_spk[CH];

  function automatic int ref_div(int mode, int base, int s);
    int dir, p, top, r, sum;
    top = (1 << RW) - 1;
    dir = (s >> (SW - 1)) & 1;
    p   = (s >> (SW - 1 - RW)) & top;
    case (mode)
      1:       r = dir ? p : top - p;
      2:       r = p;
      3:       r = dir ? top : 0;
      default: r = 0;
    endcase
    sum = base + r * (1 << SH);
    return (sum > DMAX) ? DMAX : sum;
  endfunction

  task automatic model_edge();
    bit fire, x;
    if (rst) begin
      m_sweep = 0; m_ready = 0; m_err = 0; m_mix = 0;
      for (int c = 0; c < CH; c++) begin
        m_en[c] = 0; m_mode[c] = 0; m_base[c] = 0; m_spk[c] = 0; m_next[c] = cyc + 1;
      end
    end else begin
      x = 0;
      for (int c = 0; c < CH; c++) x ^= m_spk[c];
      for (int c = 0; c < CH; c++) begin
        if (!m_en[c]) begin
          m_spk[c]  = 0;
          m_next[c] = cyc + 1;
        end else if (cyc == m_next[c]) begin
          m_spk[c]  = !m_spk[c];
          m_next[c] = cyc + ref_div(m_mode[c], m_base[c], m_sweep) + 1;
        end
      end
      fire  = cfg_valid && m_ready;
      m_err = fire && (int'(cfg_chan) >= CH);
      if (fire && int'(cfg_chan) < CH) begin
        m_en[cfg_chan]   = cfg_en;
        m_mode[cfg_chan] = int'(cfg_mode);
        m_base[cfg_chan] = int'(cfg_base);
      end
      m_ready = !fire;
      m_mix   = x;
      m_sweep = (m_sweep + 1) % (1 << SW);
    end
    cyc++;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [CH-1:0] e;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int c = 0; c < CH; c++) e[c] = m_spk[c];
    chk("spk", 32'(spk), 32'(e));
    chk("mix", 32'(mix), 32'(m_mix));
    chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  task automatic cfg(input int ch, input bit en, input int mode, input int base);
    cfg_valid = 1'b1;
    cfg_chan  = CW'(ch);
    cfg_en    = en;
    cfg_mode  = 2'(mode);
    cfg_base  = DW'(base);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_toggle(input int ch, output int n);
    logic prev;
    prev = spk[ch];
    n = 0;
    do begin
      tick();
      n++;
    end while (spk[ch] == prev && n < 600);
  endtask

  initial begin
    int n;
    logic [2:0] rdy;
    rst = 1'b1; cfg_valid = 1'b0; cfg_chan = '0; cfg_en = 1'b0; cfg_mode = 2'd0; cfg_base = '0;
    tick();
    tick();
    chk("reset_ready", 32'(cfg_ready), 32'd0);
    chk("reset_spk", 32'(spk), 32'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_reset", 32'(cfg_ready), 32'd1);

    // Fixed tone on channel 0, base 3: rise one edge after the transfer, then every 4.
    cfg(0, 1, 0, 3);
    chk("fixed_not_yet", 32'(spk[0]), 32'd0);
    tick();
    chk("fixed_rise", 32'(spk[0]), 32'd1);
    wait_toggle(0, n);
    chk("fixed_half1", 32'(n), 32'd4);
    wait_toggle(0, n);
    chk("fixed_half2", 32'(n), 32'd4);

    // Three back-to-back requests: ready 1,0,1 and two transfers.
    cfg_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rdy[i]   = cfg_ready;
      cfg_chan = CW'((i == 0) ? 1 : 2);
      cfg_en   = 1'b1;
      cfg_mode = (i == 0) ? 2'd1 : 2'd2;
      cfg_base = (i == 0) ? DW'(2) : DW'(230);
      tick();
    end
    cfg_valid = 1'b0;
    chk("ready_pattern", 32'(rdy), 32'b101);

    // Out-of-range channel: one-cycle error pulse, nothing else changes.
    tick();
    cfg(3, 1, 3, 5);
    chk("err_pulse", 32'(cfg_err), 32'd1);
    tick();
    chk("err_clear", 32'(cfg_err), 32'd0);

    for (int i = 0; i < 300; i++) tick();

    // Base change in the middle of a 21-cycle half-period.
    cfg(0, 1, 0, 20);
    wait_toggle(0, n);
    for (int i = 0; i < 5; i++) tick();
    cfg(0, 1, 0, 1);
    wait_toggle(0, n);
    chk("mid_hold", 32'(n + 6), 32'd21);
    wait_toggle(0, n);
    chk("mid_new", 32'(n), 32'd2);

    // Random configuration traffic.
    for (int k = 0; k < 40; k++) begin
      int idle;
      idle = $urandom_range(0, 40);
      for (int i = 0; i < idle; i++) tick();
      cfg($urandom_range(0, 3), ($urandom_range(0, 3) != 0), $urandom_range(0, 3),
          ($urandom_range(0, 1) != 0) ? $urandom_range(0, 40) : $urandom_range(0, 255));
    end
    for (int i = 0; i < 200; i++) tick();

    // Reset while channels are toggling.
    rst = 1'b1;
    tick();
    chk("rst_spk", 32'(spk), 32'd0);
    chk("rst_mix", 32'(mix), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    chk("stay_off", 32'(spk), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
